game_engine: RTL
================

// Module: game_engine
// PURPOSE
//  Parametrised Hangman round controller: holds secret-letter mask, accepts guesses via valid/ready,
//  classifies each (hit/miss/repeat/invalid), tracks guessed letters and wrong count, ends round
//  in WON or LOST. Sits between keyboard/guess decoder and display/score logic.
// PARAMETERS
//  ALPHA      26  alphabet size (letter indices 0..ALPHA-1)
//  MAX_WRONG  6   misses allowed; the MAX_WRONG-th miss loses the round (>=1)
//  IDX_W      5   guess index width; must satisfy 2**IDX_W >= ALPHA
//  CNT_W      3   wrong-counter width; must satisfy 2**CNT_W > MAX_WRONG
// PORTS
//  clk           in   1          clock, rising edge
//  reset         in   1          asynchronous, active-high reset
//  start         in   1          1-cycle pulse: begin new round with word_mask
//  word_mask     in   ALPHA      bit i=1 -> letter i appears in secret word; sampled on start only
//  guess_valid   in   1          guess offered
//  guess_idx     in   IDX_W      guessed letter index
//  guess_ready   out  1          high only in PLAY; transfer = guess_valid & guess_ready
//  result_valid  out  1          1-cycle pulse: result_code valid
//  result_code   out  2          0 HIT, 1 MISS, 2 REPEAT, 3 INVALID
//  guessed_mask  out  ALPHA      letters guessed this round
//  wrong_count   out  CNT_W      misses this round
//  win           out  1          high while in WON
//  lose          out  1          high while in LOST
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; secret mask register 0.
//  States: IDLE, PLAY, CHECK, WON, LOST.
//   start (any state, incl. CHECK): secret<=word_mask, guessed_mask<=0, wrong_count<=0,
//     win/lose<=0; next state PLAY, or WON directly if word_mask==0. start has priority over
//     a simultaneous transfer; a guess pending in CHECK is discarded, no result_valid.
//   PLAY: on transfer capture guess_idx -> CHECK. No transfer -> stay.
//   CHECK (1 cycle, guess_ready=0): classify captured idx:
//     idx>=ALPHA -> INVALID; guessed_mask[idx]=1 -> REPEAT: neither changes mask or count.
//     else set guessed_mask[idx]; secret[idx]=1 -> HIT, else MISS and wrong_count+1.
//     Next: LOST if wrong_count reaches MAX_WRONG; WON if (new guessed_mask & secret)==secret
//     (evaluated on post-update mask, same edge); else PLAY.
//  Latency: transfer in cycle N -> result_valid, updated mask/count, win/lose all visible in N+2;
//   guess_ready high again in N+2 if state PLAY. Max one guess per 2 cycles.
//  WON/LOST: sticky until start or reset; guess_ready=0; guesses ignored.
//  IDLE: guess_ready=0; only start leaves.
//  result_code holds last value between pulses; reset value 0.
//  wrong_count saturates at MAX_WRONG (never wraps).
// STRUCTURE
//  hangman_pkg: result_code constants (RES_HIT/MISS/REPEAT/INVALID), state enum.
//  Sub-module guess_classify (combinational): idx, secret, guessed_mask -> code, new mask,
//   miss flag, win flag. Top holds FSM and registers.
// TESTING  (ALPHA=26, MAX_WRONG=6; word "CAB": word_mask=26'h0000007)
//  1 start, guess 0,1,2 -> HIT x3; after third, win=1 in N+2, guess_ready=0, guessed_mask=26'h7.
//  2 start, guess 25,24,23,22,21,20 -> MISS x6, wrong_count 1..6, lose=1 after sixth; 7th ignored.
//  3 start, guess 0 then 0 -> HIT then REPEAT; guess 3 twice -> MISS then REPEAT; wrong_count=1.
//  4 guess_idx=27 -> INVALID, guessed_mask and wrong_count unchanged, state back to PLAY.
//  5 start with word_mask=0 -> win=1 next cycle, no guesses accepted.
//  6 async reset mid-CHECK -> all outputs 0 immediately, no result_valid; start during CHECK
//    -> new round, pending result dropped; hold guess_valid high -> one transfer per 2 cycles.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman round controller: result codes and FSM states.
package hangman_pkg;

  // Classification codes reported on result_code
  localparam logic [1:0] RES_HIT     = 2'd0;
  localparam logic [1:0] RES_MISS    = 2'd1;
  localparam logic [1:0] RES_REPEAT  = 2'd2;
  localparam logic [1:0] RES_INVALID = 2'd3;

  // Round controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

endpackage

// File: rtl/guess_classify.sv
// Combinational guess classifier: decides hit/miss/repeat/invalid for one letter
// index and produces the updated guessed-letter mask plus miss and win flags.
module guess_classify
  import hangman_pkg::*;
#(
  parameter int ALPHA = 26,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [ALPHA-1:0] secret,
  input  logic [ALPHA-1:0] guessedMask,
  output logic [1:0]       code,
  output logic [ALPHA-1:0] newMask,
  output logic             miss,
  output logic             allFound
);

  logic [ALPHA-1:0] oneHot;
  logic             inRange;
  logic             alreadyGuessed;
  logic             inWord;

  // One-hot letter select; an index past the alphabet shifts out to all zeros,
  // which doubles as the range check without indexing out of bounds.
  always_comb begin
    oneHot         = {{(ALPHA-1){1'b0}}, 1'b1} << idx;
    inRange        = |oneHot;
    alreadyGuessed = |(oneHot & guessedMask);
    inWord         = |(oneHot & secret);
  end

  // Classify and build the post-guess mask; invalid and repeat leave the mask alone
  always_comb begin
    code    = RES_INVALID;
    newMask = guessedMask;
    miss    = 1'b0;
    if (!inRange) begin
      code = RES_INVALID;
    end else if (alreadyGuessed) begin
      code = RES_REPEAT;
    end else begin
      newMask = guessedMask | oneHot;
      if (inWord) begin
        code = RES_HIT;
      end else begin
        code = RES_MISS;
        miss = 1'b1;
      end
    end
    allFound = ((newMask & secret) == secret);
  end

endmodule

// File: rtl/game_engine.sv
// Hangman round controller: owns the secret mask, accepts one guess at a time over
// valid/ready, reports each classification as a one-cycle pulse and ends the round
// in WON or LOST until the next start.
module game_engine
  import hangman_pkg::*;
#(
  parameter int ALPHA     = 26,
  parameter int MAX_WRONG = 6,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ALPHA-1:0] word_mask,
  input  logic             guess_valid,
  input  logic [IDX_W-1:0] guess_idx,
  output logic             guess_ready,
  output logic             result_valid,
  output logic [1:0]       result_code,
  output logic [ALPHA-1:0] guessed_mask,
  output logic [CNT_W-1:0] wrong_count,
  output logic             win,
  output logic             lose
);

  state_t           state_q;
  logic [ALPHA-1:0] secret_q;
  logic [ALPHA-1:0] mask_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;
  logic             resValid_q;
  logic [1:0]       resCode_q;
  logic             win_q;
  logic             lose_q;

  logic [1:0]       classCode;
  logic [ALPHA-1:0] classMask;
  logic             classMiss;
  logic             classAllFound;

  logic [CNT_W-1:0] count_d;
  logic             checkLost;
  logic             checkWon;

  guess_classify #(
    .ALPHA(ALPHA),
    .IDX_W(IDX_W)
  ) u_classify (
    .idx        (idx_q),
    .secret     (secret_q),
    .guessedMask(mask_q),
    .code       (classCode),
    .newMask    (classMask),
    .miss       (classMiss),
    .allFound   (classAllFound)
  );

  // Post-guess miss count (saturating) and round-ending decisions for the CHECK cycle
  always_comb begin
    count_d = count_q;
    if (classMiss && (count_q < CNT_W'(MAX_WRONG))) begin
      count_d = count_q + 1'b1;
    end
    checkLost = classMiss && (count_d == CNT_W'(MAX_WRONG));
    checkWon  = !checkLost && classAllFound;
  end

  // Round FSM with all outputs registered; start overrides everything, including a pending check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      secret_q   <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      resValid_q <= 1'b0;
      resCode_q  <= RES_HIT;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      resValid_q <= 1'b0;
      if (start) begin
        secret_q <= word_mask;
        mask_q   <= '0;
        count_q  <= '0;
        lose_q   <= 1'b0;
        if (word_mask == '0) begin
          state_q <= ST_WON;
          win_q   <= 1'b1;
          ready_q <= 1'b0;
        end else begin
          state_q <= ST_PLAY;
          win_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (guess_valid && ready_q) begin
              idx_q   <= guess_idx;
              ready_q <= 1'b0;
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            resValid_q <= 1'b1;
            resCode_q  <= classCode;
            mask_q     <= classMask;
            count_q    <= count_d;
            if (checkLost) begin
              state_q <= ST_LOST;
              lose_q  <= 1'b1;
            end else if (checkWon) begin
              state_q <= ST_WON;
              win_q   <= 1'b1;
            end else begin
              state_q <= ST_PLAY;
              ready_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign guess_ready  = ready_q;
  assign result_valid = resValid_q;
  assign result_code  = resCode_q;
  assign guessed_mask = mask_q;
  assign wrong_count  = count_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule
